commit_trace_aligner: RTL and testbench

- Sits between the core's writeback/commit trace taps and the dromajo co-simulation checker in the simulation harness.
- A long-latency instruction, such as a load miss, commits without its rd data. The data arrives later on the ll writeback port.
- This block buffers commits in program order and back-fills pending rd data from ll writebacks. It then emits complete, in-order records to the checker over a valid/ready handshake.

---
 rtl/commit_trace_pkg.sv | 23 ++
 rtl/oldest_match_finder.sv | 32 +++
 rtl/commit_trace_aligner.sv | 180 ++++++++++++++++++
 tb/tb_commit_trace_aligner.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_trace_pkg.sv
// Shared types and helpers for the commit trace aligner.
// Record fields are sized for the widest supported XLEN/HART_W.
package commit_trace_pkg;

  localparam int XLEN_DEF = 64;
  localparam int HART_DEF = 8;
  localparam int RD_LSB   = 7;

  typedef struct packed {
    logic [HART_DEF-1:0] hartid;
    logic [XLEN_DEF-1:0] pc;
    logic [31:0]         inst;
    logic [XLEN_DEF-1:0] wdata;
    logic                int_xcpt;
    logic [XLEN_DEF-1:0] cause;
    logic                waiting;
  } commit_rec_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/oldest_match_finder.sv
// Picks the oldest set bit of a match vector, counting from head.
// Rotate so head is bit 0, isolate lowest set bit, rotate back.
module oldest_match_finder #(
  parameter int DEPTH = 16,
  parameter int PW    = 4
) (
  input  logic [DEPTH-1:0] i_match,
  input  logic [PW-1:0]    i_head,
  output logic [DEPTH-1:0] o_onehot,
  output logic             o_hit
);

  logic [DEPTH-1:0] w_rot;
  logic [DEPTH-1:0] w_pri;

  always_comb begin
    w_rot = '0;
    for (int i = 0; i < DEPTH; i++)
      w_rot[i] = i_match[PW'(i) + i_head];
  end

  assign w_pri = w_rot & (~w_rot + DEPTH'(1));

  always_comb begin
    o_onehot = '0;
    for (int j = 0; j < DEPTH; j++)
      o_onehot[j] = w_pri[PW'(j) - i_head];
  end

  assign o_hit = |i_match;

endmodule

// File: rtl/commit_trace_aligner.sv
// In-order commit buffer that back-fills long-latency rd data.
// Define COMMIT_TRACE_TIMEOUT_EN to add the stuck-head watchdog.
module commit_trace_aligner
  import commit_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int XLEN   = 64,
  parameter int HART_W = 8
`ifdef COMMIT_TRACE_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 4096
`endif
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [HART_W-1:0]          in_hartid,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [31:0]                in_inst,
  input  logic [XLEN-1:0]            in_wdata,
  input  logic                       in_has_data,
  input  logic                       in_int_xcpt,
  input  logic [XLEN-1:0]            in_cause,
  input  logic                       ll_wen,
  input  logic [4:0]                 ll_waddr,
  input  logic [XLEN-1:0]            ll_wdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [HART_W-1:0]          out_hartid,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_inst,
  output logic [XLEN-1:0]            out_wdata,
  output logic                       out_int_xcpt,
  output logic [XLEN-1:0]            out_cause,
  output logic                       err_overflow,
  output logic                       err_orphan,
  output logic [$clog2(DEPTH):0]     occupancy
`ifdef COMMIT_TRACE_TIMEOUT_EN
  ,
  output logic                       err_timeout
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  commit_rec_t      r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             r_err_ovf;
  logic             r_err_orph;

  commit_rec_t      w_head_rec;
  commit_rec_t      w_new;
  logic             w_nonempty;
  logic             w_full;
  logic             w_show;
  logic             w_out_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_ovf;
  logic             w_orphan;
  logic             w_ll_act;
  logic [4:0]       w_rd;
  logic [DEPTH-1:0] w_match;
  logic [DEPTH-1:0] w_fill_oh;
  logic             w_hit;

  assign w_head_rec  = r_mem[r_head];
  assign w_nonempty  = (r_count != '0);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_show      = reset && w_nonempty;
  assign w_out_valid = w_show && !w_head_rec.waiting;
  assign w_pop       = w_out_valid && out_ready;
  assign w_push      = in_valid && (!w_full || w_pop);
  assign w_ovf       = in_valid && w_full && !w_pop;
  assign w_rd        = in_inst[RD_LSB +: 5];
  assign w_ll_act    = ll_wen && (ll_waddr != 5'd0);
  assign w_orphan    = w_ll_act && !w_hit;

  // Only live entries are candidates; the tail slot being written is not.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++)
      w_match[i] = w_ll_act && r_mem[i].waiting
                && (CW'(PW'(PW'(i) - r_head)) < r_count)
                && (r_mem[i].inst[RD_LSB +: 5] == ll_waddr);
  end

  oldest_match_finder #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_finder (
    .i_match  (w_match),
    .i_head   (r_head),
    .o_onehot (w_fill_oh),
    .o_hit    (w_hit)
  );

  always_comb begin
    w_new          = '0;
    w_new.hartid   = HART_DEF'(in_hartid);
    w_new.pc       = XLEN_DEF'(in_pc);
    w_new.inst     = in_inst;
    w_new.int_xcpt = in_int_xcpt;
    w_new.cause    = XLEN_DEF'(in_cause);
    w_new.waiting  = !in_has_data && !in_int_xcpt && (w_rd != 5'd0);
    if (in_has_data || w_rd != 5'd0)
      w_new.wdata  = XLEN_DEF'(in_wdata);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_err_ovf  <= 1'b0;
      r_err_orph <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i].waiting <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= w_new;
        r_tail        <= r_tail + PW'(1);
      end
      for (int i = 0; i < DEPTH; i++)
        if (w_fill_oh[i]) begin
          r_mem[i].wdata   <= XLEN_DEF'(ll_wdata);
          r_mem[i].waiting <= 1'b0;
        end
      if (w_pop)
        r_head <= r_head + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_ovf)
        r_err_ovf <= 1'b1;
      if (w_orphan)
        r_err_orph <= 1'b1;
    end
  end

  assign out_valid    = w_out_valid;
  assign out_hartid   = w_show ? w_head_rec.hartid[HART_W-1:0] : '0;
  assign out_pc       = w_show ? w_head_rec.pc[XLEN-1:0] : '0;
  assign out_inst     = w_show ? w_head_rec.inst : '0;
  assign out_wdata    = w_show ? w_head_rec.wdata[XLEN-1:0] : '0;
  assign out_int_xcpt = w_show && w_head_rec.int_xcpt;
  assign out_cause    = w_show ? w_head_rec.cause[XLEN-1:0] : '0;
  assign err_overflow = r_err_ovf;
  assign err_orphan   = r_err_orph;
  assign occupancy    = r_count;

`ifdef COMMIT_TRACE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_err_to;
  logic          w_to_run;
  logic          w_head_fill;

  assign w_to_run    = w_nonempty && w_head_rec.waiting;
  assign w_head_fill = w_fill_oh[r_head];

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_to_cnt <= '0;
      r_err_to <= 1'b0;
    end else if (!w_to_run || w_head_fill) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TW'(TIMEOUT)) begin
      r_to_cnt <= r_to_cnt + TW'(1);
      if (r_to_cnt == TW'(TIMEOUT - 1))
        r_err_to <= 1'b1;
    end
  end

  assign err_timeout = r_err_to;
`endif

endmodule

// File: tb/tb_commit_trace_aligner.sv
// Scoreboard bench for commit_trace_aligner.
// Build with COMMIT_TRACE_TIMEOUT_EN to also exercise the watchdog.
module tb_commit_trace_aligner;

  localparam int DEPTH  = 16;
  localparam int XLEN   = 64;
  localparam int HART_W = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [HART_W-1:0] in_hartid;
  logic [XLEN-1:0]   in_pc;
  logic [31:0]       in_inst;
  logic [XLEN-1:0]   in_wdata;
  logic              in_has_data;
  logic              in_int_xcpt;
  logic [XLEN-1:0]   in_cause;
  logic              ll_wen;
  logic [4:0]        ll_waddr;
  logic [XLEN-1:0]   ll_wdata;
  logic              out_valid;
  logic              out_ready;
  logic [HART_W-1:0] out_hartid;
  logic [XLEN-1:0]   out_pc;
  logic [31:0]       out_inst;
  logic [XLEN-1:0]   out_wdata;
  logic              out_int_xcpt;
  logic [XLEN-1:0]   out_cause;
  logic              err_overflow;
  logic              err_orphan;
  logic [4:0]        occupancy;
`ifdef COMMIT_TRACE_TIMEOUT_EN
  logic              err_timeout;
`endif

  typedef struct {
    logic [7:0]  hartid;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] wdata;
    logic        xcpt;
    logic [63:0] cause;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

`ifdef COMMIT_TRACE_TIMEOUT_EN
  commit_trace_aligner #(
    .DEPTH(DEPTH), .XLEN(XLEN), .HART_W(HART_W), .TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .in_hartid(in_hartid), .in_pc(in_pc), .in_inst(in_inst),
    .in_wdata(in_wdata), .in_has_data(in_has_data),
    .in_int_xcpt(in_int_xcpt), .in_cause(in_cause),
    .ll_wen(ll_wen), .ll_waddr(ll_waddr), .ll_wdata(ll_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hartid(out_hartid), .out_pc(out_pc), .out_inst(out_inst),
    .out_wdata(out_wdata), .out_int_xcpt(out_int_xcpt),
    .out_cause(out_cause), .err_overflow(err_overflow),
    .err_orphan(err_orphan), .occupancy(occupancy),
    .err_timeout(err_timeout)
  );
`else
  commit_trace_aligner #(
    .DEPTH(DEPTH), .XLEN(XLEN), .HART_W(HART_W)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .in_hartid(in_hartid), .in_pc(in_pc), .in_inst(in_inst),
    .in_wdata(in_wdata), .in_has_data(in_has_data),
    .in_int_xcpt(in_int_xcpt), .in_cause(in_cause),
    .ll_wen(ll_wen), .ll_waddr(ll_waddr), .ll_wdata(ll_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hartid(out_hartid), .out_pc(out_pc), .out_inst(out_inst),
    .out_wdata(out_wdata), .out_int_xcpt(out_int_xcpt),
    .out_cause(out_cause), .err_overflow(err_overflow),
    .err_orphan(err_orphan), .occupancy(occupancy)
  );
`endif

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted record must match the oldest expected one.
  always @(negedge clock) begin : mon
    exp_t e;
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got pc %0h expected none", out_pc);
      end else begin
        e = sbq.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_wdata", out_wdata, e.wdata);
        chk("out_inst", 64'(out_inst), 64'(e.inst));
        chk("out_xcpt", 64'(out_int_xcpt), 64'(e.xcpt));
        chk("out_cause", out_cause, e.cause);
        chk("out_hartid", 64'(out_hartid), 64'(e.hartid));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic commit(input logic [63:0] pc, input logic [4:0] rd,
                        input logic [6:0] op, input logic [63:0] wd,
                        input logic has, input logic xc,
                        input logic [63:0] cause, input logic enq,
                        input logic [63:0] exp_wd);
    exp_t e;
    in_valid    = 1'b1;
    in_hartid   = 8'h01;
    in_pc       = pc;
    in_inst     = {17'h0, 3'b000, rd, op};
    in_wdata    = wd;
    in_has_data = has;
    in_int_xcpt = xc;
    in_cause    = cause;
    if (enq) begin
      e.hartid = 8'h01;
      e.pc     = pc;
      e.inst   = {17'h0, 3'b000, rd, op};
      e.wdata  = exp_wd;
      e.xcpt   = xc;
      e.cause  = cause;
      sbq.push_back(e);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic ll(input logic [4:0] a, input logic [63:0] d);
    ll_wen   = 1'b1;
    ll_waddr = a;
    ll_wdata = d;
    step();
    ll_wen = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 64 && sbq.size() != 0; i++)
      step();
    chk(name, 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0; in_hartid = '0; in_pc = '0; in_inst = '0;
    in_wdata = '0; in_has_data = 1'b0; in_int_xcpt = 1'b0;
    in_cause = '0; ll_wen = 1'b0; ll_waddr = '0; ll_wdata = '0;
    out_ready = 1'b0;
    repeat (3) step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_ovf", 64'(err_overflow), 64'd0);
    chk("rst_orph", 64'(err_orphan), 64'd0);
    chk("rst_pc", out_pc, 64'd0);
    reset = 1'b1;
    step();

    // complete commit, one-cycle latency
    out_ready = 1'b1;
    commit(64'h8000_0000, 5'd1, 7'h33, 64'h5, 1, 0, 0, 1, 64'h5);
    chk("lat_valid", 64'(out_valid), 64'd1);
    step();
    chk("t1_occ", 64'(occupancy), 64'd0);

    // waiting load blocks younger ADD until filled
    commit(64'h8000_0004, 5'd10, 7'h03, 64'h0, 0, 0, 0, 1, 64'hDEAD);
    commit(64'h8000_0008, 5'd11, 7'h33, 64'h7, 1, 0, 0, 1, 64'h7);
    repeat (3) step();
    chk("t2_blocked", 64'(out_valid), 64'd0);
    chk("t2_occ", 64'(occupancy), 64'd2);
    ll(5'd10, 64'hDEAD);
    drain("t2_drain");
    chk("t2_occ_end", 64'(occupancy), 64'd0);

    // same rd twice: fills go oldest first
    commit(64'h8000_0010, 5'd5, 7'h03, 64'h0, 0, 0, 0, 1, 64'h1);
    commit(64'h8000_0014, 5'd5, 7'h03, 64'h0, 0, 0, 0, 1, 64'h2);
    ll(5'd5, 64'h1);
    ll(5'd5, 64'h2);
    drain("t3_drain");

    // x0 ll ignored, unmatched ll flagged, exception never waits
    ll(5'd0, 64'h123);
    chk("x0_orph", 64'(err_orphan), 64'd0);
    ll(5'd7, 64'h55);
    chk("orphan", 64'(err_orphan), 64'd1);
    commit(64'h8000_0020, 5'd3, 7'h73, 64'h99, 0, 1,
           64'h8000_0000_0000_0007, 1, 64'h99);
    chk("xcpt_valid", 64'(out_valid), 64'd1);
    drain("t4_drain");

    // fill to full, overflow, then push+pop while full
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      commit(64'h1000 + 64'(4 * i), 5'd1, 7'h33, 64'(i), 1, 0, 0, 1, 64'(i));
    chk("full_occ", 64'(occupancy), 64'd16);
    chk("full_noovf", 64'(err_overflow), 64'd0);
    chk("stall_pc", out_pc, 64'h1000);
    step();
    step();
    chk("stable_pc", out_pc, 64'h1000);
    commit(64'hDEAD_0000, 5'd1, 7'h33, 64'hBAD, 1, 0, 0, 0, 64'h0);
    chk("ovf_flag", 64'(err_overflow), 64'd1);
    chk("ovf_occ", 64'(occupancy), 64'd16);
    out_ready = 1'b1;
    commit(64'h2000, 5'd2, 7'h33, 64'h77, 1, 0, 0, 1, 64'h77);
    chk("pushpop_occ", 64'(occupancy), 64'd16);
    drain("t5_drain");
    chk("t5_occ_end", 64'(occupancy), 64'd0);

    // stuck head, then reset mid-stream discards everything
    commit(64'h3000, 5'd9, 7'h03, 64'h0, 0, 0, 0, 0, 64'h0);
    commit(64'h3004, 5'd4, 7'h33, 64'h44, 1, 0, 0, 0, 64'h0);
`ifdef COMMIT_TRACE_TIMEOUT_EN
    repeat (3) step();
    chk("to_early", 64'(err_timeout), 64'd0);
    repeat (10) step();
    chk("to_set", 64'(err_timeout), 64'd1);
`endif
    chk("pre_rst_occ", 64'(occupancy), 64'd2);
    reset = 1'b0;
    step();
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_occ", 64'(occupancy), 64'd0);
    chk("mr_pc", out_pc, 64'd0);
    chk("mr_wdata", out_wdata, 64'd0);
    chk("mr_ovf", 64'(err_overflow), 64'd0);
    chk("mr_orph", 64'(err_orphan), 64'd0);
`ifdef COMMIT_TRACE_TIMEOUT_EN
    chk("mr_to", 64'(err_timeout), 64'd0);
`endif
    reset = 1'b1;
    repeat (3) step();
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
